// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared types, opcodes, state encoding and strobe bit indices for the hardwired CPU control unit.
// Contents: package cpu_ctrl_pkg (OPC_W, ST_W, state_t, opclass_t, OP_* opcodes,
//   B_*/R_*/A_*/G_*/M_* bit indices for bus_out/reg_in/alu_op/gpr_ctl/misc, decode helper functions).
// Optional build macro used by importers: MEM_WAIT_EN.
package cpu_ctrl_pkg;
    localparam int OPC_W = 5;
    localparam int ST_W  = 4;
    localparam int BUS_W = 11;
    localparam int REG_W = 10;
    localparam int ALU_W = 13;
    localparam int GPR_W = 6;
    localparam int MSC_W = 6;

    typedef enum logic [ST_W-1:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
    } state_t;

    typedef enum logic [4:0] {
        C_ALU3, C_ALUI, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY, C_BRX, C_JR,
        C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
    } opclass_t;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                                 OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                                 OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                                 OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
                                 OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                                 OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001,
                                 OP_NOT  = 5'b10010, OP_BRX  = 5'b10011, OP_JR   = 5'b10100,
                                 OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                                 OP_MFLO = 5'b11000, OP_MFHI = 5'b11001, OP_NOP  = 5'b11010,
                                 OP_HALT = 5'b11011;

    localparam int B_HIOUT = 10, B_LOOUT = 9, B_ZHIGHOUT = 8, B_ZLOWOUT = 7, B_PCOUT = 6,
                   B_IROUT = 5, B_MDROUT = 4, B_INOUT = 3, B_COUT = 2, B_YOUT = 1, B_MAROUT = 0;
    localparam int R_HIIN = 9, R_LOIN = 8, R_PCIN = 7, R_IRIN = 6, R_ZIN = 5, R_YIN = 4,
                   R_MARIN = 3, R_MDRIN = 2, R_CONIN = 1, R_OUTPORTIN = 0;
    localparam int A_AND = 12, A_OR = 11, A_ADD = 10, A_SUB = 9, A_MUL = 8, A_DIV = 7, A_SHR = 6,
                   A_SHRA = 5, A_SHL = 4, A_ROR = 3, A_ROL = 2, A_NEG = 1, A_NOT = 0;
    localparam int G_GRA = 5, G_GRB = 4, G_GRC = 3, G_RIN = 2, G_ROUT = 1, G_BAOUT = 0;
    localparam int M_READ = 5, M_INCPC = 4, M_READ_MEM = 3, M_WRITE_MEM = 2, M_CON_RESET = 1, M_PCSAVE = 0;

    function automatic opclass_t op_class(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_LD:                                   return C_LD;
            OP_LDI:                                  return C_LDI;
            OP_ST:                                   return C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:         return C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:                return C_ALUI;
            OP_DIV, OP_MUL:                          return C_MULDIV;
            OP_NEG, OP_NOT:                          return C_UNARY;
            OP_BRX:                                  return C_BRX;
            OP_JR:                                   return C_JR;
            OP_JAL:                                  return C_JAL;
            OP_IN:                                   return C_IN;
            OP_OUT:                                  return C_OUT;
            OP_MFHI:                                 return C_MFHI;
            OP_MFLO:                                 return C_MFLO;
            OP_NOP:                                  return C_NOP;
            OP_HALT:                                 return C_HALT;
            default:                                 return C_ILL;
        endcase
    endfunction

    // ALU function named by the opcode itself; address arithmetic picks ADD separately.
    function automatic logic [ALU_W-1:0] alu_sel(input logic [OPC_W-1:0] opc);
        logic [ALU_W-1:0] a;
        a = '0;
        case (opc)
            OP_ADD, OP_ADDI: a[A_ADD]  = 1'b1;
            OP_SUB:          a[A_SUB]  = 1'b1;
            OP_AND, OP_ANDI: a[A_AND]  = 1'b1;
            OP_OR, OP_ORI:   a[A_OR]   = 1'b1;
            OP_ROR:          a[A_ROR]  = 1'b1;
            OP_ROL:          a[A_ROL]  = 1'b1;
            OP_SHR:          a[A_SHR]  = 1'b1;
            OP_SHRA:         a[A_SHRA] = 1'b1;
            OP_SHL:          a[A_SHL]  = 1'b1;
            OP_DIV:          a[A_DIV]  = 1'b1;
            OP_MUL:          a[A_MUL]  = 1'b1;
            OP_NEG:          a[A_NEG]  = 1'b1;
            OP_NOT:          a[A_NOT]  = 1'b1;
            default:         a = '0;
        endcase
        return a;
    endfunction

    // Final T-state of each class; nop/illegal finish at the end of fetch.
    function automatic state_t last_step(input opclass_t c);
        case (c)
            C_ALU3, C_ALUI, C_LDI:              return S_T5;
            C_LD, C_ST:                         return S_T7;
            C_MULDIV, C_BRX:                    return S_T6;
            C_UNARY, C_JAL:                     return S_T4;
            C_JR, C_IN, C_OUT, C_MFHI, C_MFLO:  return S_T3;
            default:                            return S_T2;
        endcase
    endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: datapath <-> control unit signal bundle.
// master (datapath/bench): drives ir, con_ff, mem_rdy, stop; receives bus_out, reg_in, alu_op, gpr_ctl, misc, run, illegal.
// slave (control_sequencer): the reverse directions.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;
    logic [31:0]      ir;
    logic             con_ff;
    logic             mem_rdy;
    logic             stop;
    logic [BUS_W-1:0] bus_out;
    logic [REG_W-1:0] reg_in;
    logic [ALU_W-1:0] alu_op;
    logic [GPR_W-1:0] gpr_ctl;
    logic [MSC_W-1:0] misc;
    logic             run;
    logic             illegal;

    modport master (
        output ir, con_ff, mem_rdy, stop,
        input  bus_out, reg_in, alu_op, gpr_ctl, misc, run, illegal
    );
    modport slave (
        input  ir, con_ff, mem_rdy, stop,
        output bus_out, reg_in, alu_op, gpr_ctl, misc, run, illegal
    );
endinterface

// File: rtl/control_sequencer_ctrl_decode.sv
// ctrl_decode: combinational Moore decode of (state, opcode, con_ff) into every datapath control strobe.
// Inputs: i_state, i_opc, i_con_ff. Outputs: o_bus_out, o_reg_in, o_alu_op, o_gpr_ctl, o_misc, o_run, o_illegal.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t           i_state,
    input  logic [OPC_W-1:0] i_opc,
    input  logic             i_con_ff,
    output logic [BUS_W-1:0] o_bus_out,
    output logic [REG_W-1:0] o_reg_in,
    output logic [ALU_W-1:0] o_alu_op,
    output logic [GPR_W-1:0] o_gpr_ctl,
    output logic [MSC_W-1:0] o_misc,
    output logic             o_run,
    output logic             o_illegal
);
    opclass_t         w_cls;
    logic [ALU_W-1:0] w_alu;

    assign w_cls = op_class(i_opc);
    assign w_alu = alu_sel(i_opc);

    always_comb begin
        o_bus_out = '0;
        o_reg_in  = '0;
        o_alu_op  = '0;
        o_gpr_ctl = '0;
        o_misc    = '0;
        o_run     = (i_state != S_RST) && (i_state != S_PAUSE) && (i_state != S_HALT);
        o_illegal = (i_state == S_T2) && (w_cls == C_ILL);
        case (i_state)
            S_RST: o_misc[M_CON_RESET] = 1'b1;
            S_T0: begin
                o_bus_out[B_PCOUT] = 1'b1;
                o_reg_in[R_MARIN]  = 1'b1;
                o_reg_in[R_PCIN]   = 1'b1;
                o_misc[M_INCPC]    = 1'b1;
            end
            S_T1: begin
                o_misc[M_READ]     = 1'b1;
                o_misc[M_READ_MEM] = 1'b1;
                o_reg_in[R_MDRIN]  = 1'b1;
            end
            S_T2: begin
                o_bus_out[B_MDROUT] = 1'b1;
                o_reg_in[R_IRIN]    = 1'b1;
            end
            S_T3: case (w_cls)
                C_ALU3, C_ALUI: begin
                    o_gpr_ctl[G_GRB] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_reg_in[R_YIN] = 1'b1;
                end
                C_LDI, C_LD, C_ST: begin
                    o_gpr_ctl[G_GRB] = 1'b1; o_gpr_ctl[G_BAOUT] = 1'b1; o_reg_in[R_YIN] = 1'b1;
                end
                C_MULDIV: begin
                    o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_reg_in[R_YIN] = 1'b1;
                end
                C_UNARY: begin
                    o_gpr_ctl[G_GRB] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_alu_op = w_alu; o_reg_in[R_ZIN] = 1'b1;
                end
                C_BRX: begin
                    o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_reg_in[R_CONIN] = 1'b1;
                end
                C_JR: begin
                    o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_reg_in[R_PCIN] = 1'b1;
                end
                C_JAL: begin
                    o_bus_out[B_PCOUT] = 1'b1; o_misc[M_PCSAVE] = 1'b1;
                end
                C_IN: begin
                    o_bus_out[B_INOUT] = 1'b1; o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_RIN] = 1'b1;
                end
                C_OUT: begin
                    o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_reg_in[R_OUTPORTIN] = 1'b1;
                end
                C_MFHI: begin
                    o_bus_out[B_HIOUT] = 1'b1; o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_RIN] = 1'b1;
                end
                C_MFLO: begin
                    o_bus_out[B_LOOUT] = 1'b1; o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_RIN] = 1'b1;
                end
                default: ;
            endcase
            S_T4: case (w_cls)
                C_ALU3: begin
                    o_gpr_ctl[G_GRC] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_alu_op = w_alu; o_reg_in[R_ZIN] = 1'b1;
                end
                C_ALUI: begin
                    o_bus_out[B_COUT] = 1'b1; o_alu_op = w_alu; o_reg_in[R_ZIN] = 1'b1;
                end
                C_LDI, C_LD, C_ST: begin
                    o_bus_out[B_COUT] = 1'b1; o_alu_op[A_ADD] = 1'b1; o_reg_in[R_ZIN] = 1'b1;
                end
                C_MULDIV: begin
                    o_gpr_ctl[G_GRB] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_alu_op = w_alu; o_reg_in[R_ZIN] = 1'b1;
                end
                C_UNARY: begin
                    o_bus_out[B_ZLOWOUT] = 1'b1; o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_RIN] = 1'b1;
                end
                C_BRX: begin
                    o_bus_out[B_PCOUT] = 1'b1; o_reg_in[R_YIN] = 1'b1;
                end
                C_JAL: begin
                    o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_reg_in[R_PCIN] = 1'b1;
                end
                default: ;
            endcase
            S_T5: case (w_cls)
                C_ALU3, C_ALUI, C_LDI: begin
                    o_bus_out[B_ZLOWOUT] = 1'b1; o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_RIN] = 1'b1;
                end
                C_LD, C_ST: begin
                    o_bus_out[B_ZLOWOUT] = 1'b1; o_reg_in[R_MARIN] = 1'b1;
                end
                C_MULDIV: begin
                    o_bus_out[B_ZLOWOUT] = 1'b1; o_reg_in[R_LOIN] = 1'b1;
                end
                C_BRX: begin
                    o_bus_out[B_COUT] = 1'b1; o_alu_op[A_ADD] = 1'b1; o_reg_in[R_ZIN] = 1'b1;
                end
                default: ;
            endcase
            S_T6: case (w_cls)
                C_LD: begin
                    o_misc[M_READ] = 1'b1; o_misc[M_READ_MEM] = 1'b1; o_reg_in[R_MDRIN] = 1'b1;
                end
                C_ST: begin
                    o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_ROUT] = 1'b1; o_reg_in[R_MDRIN] = 1'b1;
                end
                C_MULDIV: begin
                    o_bus_out[B_ZHIGHOUT] = 1'b1; o_reg_in[R_HIIN] = 1'b1;
                end
                C_BRX: begin
                    // The branch target is always on the bus; only the PC load is conditional.
                    o_bus_out[B_ZLOWOUT] = 1'b1; o_reg_in[R_PCIN] = i_con_ff;
                end
                default: ;
            endcase
            S_T7: case (w_cls)
                C_LD: begin
                    o_bus_out[B_MDROUT] = 1'b1; o_gpr_ctl[G_GRA] = 1'b1; o_gpr_ctl[G_RIN] = 1'b1;
                end
                C_ST: o_misc[M_WRITE_MEM] = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state sequencer for the CPU datapath; owns the state register and transitions.
// Ports: clk, reset (synchronous, active-low), bus (control_sequencer_if.slave: ir, con_ff, mem_rdy, stop in;
//   bus_out, reg_in, alu_op, gpr_ctl, misc, run, illegal out).
// Build option: MEM_WAIT_EN makes T1, ld-T6 and st-T7 wait for mem_rdy.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input logic           clk,
    input logic           reset,
    control_sequencer_if.slave bus
);
    state_t           r_state;
    state_t           w_next;
    logic [OPC_W-1:0] r_opc;
    logic [OPC_W-1:0] w_opc;
    opclass_t         w_cls;
    logic             w_wait;

    // During T2 the IR is being loaded, so decode straight from it; afterwards use the latched copy.
    assign w_opc = (r_state == S_T2) ? bus.ir[31:27] : r_opc;
    assign w_cls = op_class(w_opc);

`ifdef MEM_WAIT_EN
    assign w_wait = !bus.mem_rdy && ((r_state == S_T1) ||
                                     (w_cls == C_LD && r_state == S_T6) ||
                                     (w_cls == C_ST && r_state == S_T7));
`else
    assign w_wait = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RST;
            r_opc   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2) r_opc <= w_opc;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:   w_next = S_T0;
            S_PAUSE: w_next = bus.stop ? S_PAUSE : S_T0;
            S_HALT:  w_next = S_HALT;
            default:
                if (w_wait)
                    w_next = r_state;
                else if (r_state == S_T2 && w_cls == C_HALT)
                    w_next = S_HALT;
                else if (r_state == last_step(w_cls))
                    w_next = bus.stop ? S_PAUSE : S_T0;
                else
                    w_next = state_t'(r_state + 1'b1);
        endcase
    end

    ctrl_decode u_decode (
        .i_state   (r_state),
        .i_opc     (w_opc),
        .i_con_ff  (bus.con_ff),
        .o_bus_out (bus.bus_out),
        .o_reg_in  (bus.reg_in),
        .o_alu_op  (bus.alu_op),
        .o_gpr_ctl (bus.gpr_ctl),
        .o_misc    (bus.misc),
        .o_run     (bus.run),
        .o_illegal (bus.illegal)
    );
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed + randomized checks of control_sequencer against a recipe-driven instruction model.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if bus_if ();
    control_sequencer dut (.clk(clk), .reset(reset), .bus(bus_if.slave));

    int n_chk = 0;
    int n_pass = 0;

    // Strobe names in output order: {bus_out, reg_in, alu_op, gpr_ctl, misc}; names[i] is bit 45-i.
    string names[46] = '{"HIout","LOout","Zhighout","Zlowout","PCout","IRout","MDRout","INout","Cout","Yout","MARout",
                         "HIin","LOin","PCin","IRin","Zin","Yin","MARin","MDRin","CONin","OUT_Portin",
                         "AND","OR","ADD","SUB","MUL","DIV","SHR","SHRA","SHL","ROR","ROL","NEG","NOT",
                         "Gra","Grb","Grc","Rin","Rout","BAout",
                         "Read","IncPC","read_mem","write_mem","CON_RESET","PCSave"};

    function automatic string opname(input logic [4:0] op);
        case (op)
            3, 12: return "ADD";
            4: return "SUB";
            5, 13: return "AND";
            6, 14: return "OR";
            7: return "ROR";
            8: return "ROL";
            9: return "SHR";
            10: return "SHRA";
            11: return "SHL";
            15: return "DIV";
            16: return "MUL";
            17: return "NEG";
            18: return "NOT";
            default: return "";
        endcase
    endfunction

    // Each instruction as a '|'-separated list of steps; OP = opcode's ALU function, PCin? = PCin if con_ff.
    function automatic string recipe(input logic [4:0] op);
        string f;
        f = "PCout MARin IncPC PCin|Read MDRin read_mem|MDRout IRin";
        case (op)
            0: return {f, "|Grb BAout Yin|Cout ADD Zin|Zlowout MARin|Read MDRin read_mem|MDRout Gra Rin"};
            1: return {f, "|Grb BAout Yin|Cout ADD Zin|Zlowout Gra Rin"};
            2: return {f, "|Grb BAout Yin|Cout ADD Zin|Zlowout MARin|Gra Rout MDRin|write_mem"};
            3, 4, 5, 6, 7, 8, 9, 10, 11: return {f, "|Grb Rout Yin|Grc Rout OP Zin|Zlowout Gra Rin"};
            12, 13, 14: return {f, "|Grb Rout Yin|Cout OP Zin|Zlowout Gra Rin"};
            15, 16: return {f, "|Gra Rout Yin|Grb Rout OP Zin|Zlowout LOin|Zhighout HIin"};
            17, 18: return {f, "|Grb Rout OP Zin|Zlowout Gra Rin"};
            19: return {f, "|Gra Rout CONin|PCout Yin|Cout ADD Zin|Zlowout PCin?"};
            20: return {f, "|Gra Rout PCin"};
            21: return {f, "|PCout PCSave|Gra Rout PCin"};
            22: return {f, "|INout Gra Rin"};
            23: return {f, "|Gra Rout OUT_Portin"};
            24: return {f, "|LOout Gra Rin"};
            25: return {f, "|HIout Gra Rin"};
            default: return f;
        endcase
    endfunction

    function automatic int nsteps(input string s);
        int n;
        n = 1;
        for (int i = 0; i < s.len(); i++) if (s[i] == "|") n++;
        return n;
    endfunction

    function automatic string step_of(input string s, input int k);
        string r;
        int n;
        r = "";
        n = 0;
        for (int i = 0; i < s.len(); i++)
            if (s[i] == "|") n++;
            else if (n == k) r = {r, s.substr(i, i)};
        return r;
    endfunction

    function automatic logic [45:0] ctl_of(input string st, input logic [4:0] op, input logic cf);
        logic [45:0] v;
        string tok;
        v = '0;
        tok = "";
        for (int i = 0; i <= st.len(); i++)
            if (i == st.len() || st[i] == " ") begin
                if (tok == "OP") tok = opname(op);
                if (tok == "PCin?") tok = cf ? "PCin" : "";
                for (int j = 0; j < 46; j++) if (tok == names[j]) v[45-j] = 1'b1;
                tok = "";
            end else tok = {tok, st.substr(i, i)};
        return v;
    endfunction

    // Model: mode 0=reset 1=executing 2=paused 3=halted; m_k = step within current instruction.
    int m_mode = 0;
    int m_k = 0;
    logic [4:0] m_op = 5'd0;

    function automatic bit mem_hold(input logic [4:0] c);
`ifdef MEM_WAIT_EN
        return m_mode == 1 && !bus_if.mem_rdy && (m_k == 1 || (c == 0 && m_k == 6) || (c == 2 && m_k == 7));
`else
        return c == 5'd31 && 1'b0;
`endif
    endfunction

    always @(posedge clk) begin : model
        logic [4:0] c;
        c = (m_k == 2) ? bus_if.ir[31:27] : m_op;
        if (!reset) m_mode <= 0;
        else case (m_mode)
            0: begin m_mode <= 1; m_k <= 0; end
            1: if (mem_hold(c)) ;
               else if (m_k == 2 && c == 5'd27) m_mode <= 3;
               else if (m_k == nsteps(recipe(c)) - 1) begin m_mode <= bus_if.stop ? 2 : 1; m_k <= 0; end
               else m_k <= m_k + 1;
            2: if (!bus_if.stop) begin m_mode <= 1; m_k <= 0; end
            default: ;
        endcase
        if (reset && m_mode == 1 && m_k == 2) m_op <= c;
    end

    function automatic logic [47:0] expected();
        logic [4:0] c;
        c = (m_k <= 2) ? bus_if.ir[31:27] : m_op;
        case (m_mode)
            0: return {ctl_of("CON_RESET", 5'd0, 1'b0), 2'b00};
            1: return {ctl_of(step_of(recipe(c), m_k), c, bus_if.con_ff), 1'b1, m_k == 2 && c > 5'd27};
            default: return 48'd0;
        endcase
    endfunction

    // Every-cycle comparison against the model, away from the clock edge.
    initial forever begin
        logic [47:0] got, exp;
        @(posedge clk);
        #3;
        got = {bus_if.bus_out, bus_if.reg_in, bus_if.alu_op, bus_if.gpr_ctl, bus_if.misc, bus_if.run, bus_if.illegal};
        exp = expected();
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL model t=%0t mode=%0d k=%0d: got %h expected %h", $time, m_mode, m_k, got, exp);
    end

    task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    initial begin
        bus_if.ir = 32'h0;
        bus_if.con_ff = 1'b0;
        bus_if.mem_rdy = 1'b1;
        bus_if.stop = 1'b0;
        repeat (2) @(negedge clk);
        lit("rst_misc", bus_if.misc, 6'b000010);
        lit("rst_run", bus_if.run, 0);
        lit("rst_rest", {bus_if.bus_out, bus_if.reg_in, bus_if.alu_op, bus_if.gpr_ctl, bus_if.illegal}, 0);
        // add: six cycles, T0 again on cycle 7
        bus_if.ir = 32'h18000000;
        reset = 1'b1;
        @(negedge clk);
        lit("t0_bus", bus_if.bus_out, 11'h040);
        lit("t0_reg", bus_if.reg_in, 10'h088);
        lit("t0_misc", bus_if.misc, 6'h10);
        repeat (5) @(negedge clk);
        lit("add_t5_bus", bus_if.bus_out, 11'h080);
        lit("add_t5_gpr", bus_if.gpr_ctl, 6'h24);
        @(negedge clk);
        lit("add_wrap", bus_if.bus_out, 11'h040);
        // reset in the middle of add T4
        repeat (4) @(negedge clk);
        lit("add_t4_alu", bus_if.alu_op, 13'h0400);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        lit("midrst_misc", bus_if.misc, 6'b000010);
        lit("midrst_rest", {bus_if.bus_out, bus_if.reg_in, bus_if.alu_op, bus_if.gpr_ctl, bus_if.run}, 0);
        reset = 1'b1;
        @(negedge clk);
        lit("after_rst_t0", {bus_if.bus_out[6], bus_if.reg_in[3], bus_if.misc[4], bus_if.reg_in[7]}, 4'hf);
        // brx taken / not taken
        bus_if.ir = 32'h98000000;
        bus_if.con_ff = 1'b1;
        repeat (6) @(negedge clk);
        lit("brx_taken_pcin", bus_if.reg_in[7], 1);
        @(negedge clk);
        bus_if.con_ff = 1'b0;
        repeat (6) @(negedge clk);
        lit("brx_nt_pcin", bus_if.reg_in[7], 0);
        lit("brx_nt_zlow", bus_if.bus_out, 11'h080);
        @(negedge clk);
        // mul with stop raised in T4
        bus_if.ir = 32'h80000000;
        repeat (4) @(negedge clk);
        lit("mul_t4_alu", bus_if.alu_op, 13'h0100);
        bus_if.stop = 1'b1;
        repeat (2) @(negedge clk);
        lit("mul_t6_bus", bus_if.bus_out, 11'h100);
        @(negedge clk);
        lit("pause_run", bus_if.run, 0);
        lit("pause_bus", bus_if.bus_out, 0);
        bus_if.stop = 1'b0;
        @(negedge clk);
        lit("unpause_run", bus_if.run, 1);
        lit("unpause_t0", bus_if.bus_out, 11'h040);
        // halt is sticky until reset
        bus_if.ir = 32'hD8000000;
        repeat (3) @(negedge clk);
        lit("halt_run", bus_if.run, 0);
        for (int i = 0; i < 4; i++) begin
            bus_if.stop = ~bus_if.stop;
            @(negedge clk);
            lit("halt_sticky", {bus_if.run, bus_if.bus_out, bus_if.misc}, 0);
        end
        bus_if.stop = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        lit("halt_rst", bus_if.misc, 6'b000010);
        reset = 1'b1;
        @(negedge clk);
        lit("halt_exit_t0", bus_if.bus_out, 11'h040);
`ifdef MEM_WAIT_EN
        bus_if.ir = 32'h0;
        repeat (5) @(negedge clk);
        bus_if.mem_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lit("ld_wait_readmem", bus_if.misc[3], 1);
            if (i == 3) bus_if.mem_rdy = 1'b1;
        end
        @(negedge clk);
        lit("ld_t7_bus", bus_if.bus_out, 11'h010);
        lit("ld_t7_gpr", bus_if.gpr_ctl, 6'h24);
`endif
        // randomized traffic, model-checked every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) != 0);
            bus_if.stop = ($urandom_range(0, 9) == 0);
            bus_if.con_ff = 1'($urandom);
            bus_if.mem_rdy = ($urandom_range(0, 3) != 0);
            if (m_mode != 1 || m_k < 2) bus_if.ir = {5'($urandom_range(0, 31)), 27'($urandom)};
            if (m_mode == 3 && $urandom_range(0, 3) == 0) reset = 1'b0;
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
